// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver, 16x oversampled with 3-sample majority
//               voting, feeding a first-word-fall-through byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  baudclk16,
    input  logic                  rxd,
    input  logic                  rd_strobe,
    input  logic                  clr_err,
    output logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  rx_overrun,
    output logic                  frame_err
);

    localparam int                    c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL    = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_rxd_meta, r_rxd_s;
    logic        r_rd_q;
    logic [3:0]  r_phase, w_phase_next;
    logic [2:0]  r_bit_idx, w_bit_idx_next;
    logic [7:0]  r_shreg, w_shreg_next;
    logic        r_samp7, r_samp8, w_samp7_next, w_samp8_next;
    logic        w_majority, w_push, w_frame_set;

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_empty, w_full, w_pop_edge, w_do_pop, w_do_push, w_overrun_set;

    // ---------------------------------------------------------------- receiver
    always_comb begin
        w_state_next   = r_state;
        w_phase_next   = r_phase;
        w_bit_idx_next = r_bit_idx;
        w_shreg_next   = r_shreg;
        w_samp7_next   = r_samp7;
        w_samp8_next   = r_samp8;
        w_push         = 1'b0;
        w_frame_set    = 1'b0;
        w_majority     = (r_samp7 & r_samp8) | (r_samp7 & r_rxd_s) | (r_samp8 & r_rxd_s);

        if (baudclk16) begin
            w_phase_next = r_phase + 4'd1;
            if (r_phase == 4'd7) w_samp7_next = r_rxd_s;
            if (r_phase == 4'd8) w_samp8_next = r_rxd_s;

            case (r_state)
                S_IDLE: begin
                    w_phase_next = r_phase;
                    // The detecting tick is phase 0 of the start bit.
                    if (!r_rxd_s) begin
                        w_state_next = S_START;
                        w_phase_next = 4'd1;
                    end
                end
                S_START: begin
                    if (r_phase == 4'd9 && w_majority) begin
                        w_state_next = S_IDLE;
                    end else if (r_phase == 4'd15) begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = 3'd0;
                    end
                end
                S_DATA: begin
                    if (r_phase == 4'd9) w_shreg_next[r_bit_idx] = w_majority;
                    if (r_phase == 4'd15) begin
                        if (r_bit_idx == 3'd7) w_state_next = S_STOP;
                        else                   w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
                S_STOP: begin
                    if (r_phase == 4'd9) begin
                        if (w_majority) begin
                            w_push       = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_frame_set  = 1'b1;
                            w_state_next = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (r_rxd_s) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_phase    <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shreg    <= 8'h00;
            r_samp7    <= 1'b1;
            r_samp8    <= 1'b1;
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rd_q     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_phase    <= w_phase_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shreg    <= w_shreg_next;
            r_samp7    <= w_samp7_next;
            r_samp8    <= w_samp8_next;
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
            r_rd_q     <= rd_strobe;
        end
    end

    // -------------------------------------------------------------------- fifo
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign w_pop_edge = rd_strobe & ~r_rd_q;
    assign w_do_pop   = w_pop_edge & ~w_empty;
    // A full FIFO still accepts the byte when the same clk frees a slot.
    assign w_do_push     = w_push & (~w_full | w_do_pop);
    assign w_overrun_set = w_push & w_full & ~w_do_pop;

    always_ff @(posedge clk) begin
        if (resetn && w_do_push) r_mem[r_wr_ptr] <= r_shreg;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_overrun_set) rx_overrun <= 1'b1;
            else if (clr_err)  rx_overrun <= 1'b0;
            if (w_frame_set)   frame_err  <= 1'b1;
            else if (clr_err)  frame_err  <= 1'b0;
        end
    end

    assign rx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign rx_ready = ~w_empty;
    assign rx_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Scoreboard bench for uart_rx_fifo (frames, glitch, overrun,
//               framing error, push/pop collision, mid-frame reset).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int c_DEPTH_LOG2 = 2;
    localparam int c_DEPTH      = 1 << c_DEPTH_LOG2;

    logic                  clk = 1'b0;
    logic                  resetn, baudclk16, rxd, rd_strobe, clr_err;
    logic [7:0]            rx_data;
    logic                  rx_ready, rx_overrun, frame_err;
    logic [c_DEPTH_LOG2:0] rx_count;

    logic [7:0] exp_q[$];
    logic       exp_ovr, exp_ferr;
    int         n_checks = 0;
    int         n_fail   = 0;

    uart_rx_fifo #(.DEPTH_LOG2(c_DEPTH_LOG2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .baudclk16  (baudclk16),
        .rxd        (rxd),
        .rd_strobe  (rd_strobe),
        .clr_err    (clr_err),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_count   (rx_count),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // One tick every 4 clks, changed on the falling edge.
    initial begin
        baudclk16 = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baudclk16 = 1'b1;
            @(negedge clk);
            baudclk16 = 1'b0;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns on the falling edge after the n-th tick.
    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baudclk16) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low, input bit pop_at_push);
        logic [7:0] head;
        rxd = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick_wait(16);
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            tick_wait(stop_low);
            rxd = 1'b1;
            tick_wait(2);
            exp_ferr = 1'b1;
        end else if (pop_at_push) begin
            rxd = 1'b1;
            tick_wait(9);
            // Raise rd_strobe so its first sampling edge is the stop phase-9 tick.
            repeat (3) @(negedge clk);
            head = exp_q.pop_front();
            check_val("collide_pop_data", 32'(rx_data), 32'(head));
            rd_strobe = 1'b1;
            exp_q.push_back(b);
            @(negedge clk);
            rd_strobe = 1'b0;
            tick_wait(6);
        end else begin
            rxd = 1'b1;
            tick_wait(16);
            if (exp_q.size() < c_DEPTH) exp_q.push_back(b);
            else                        exp_ovr = 1'b1;
        end
    endtask

    task automatic pop_byte(input int hold);
        logic [7:0] head;
        @(negedge clk);
        head = (exp_q.size() == 0) ? 8'h00 : exp_q.pop_front();
        check_val("pop_data", 32'(rx_data), 32'(head));
        rd_strobe = 1'b1;
        repeat (hold) @(negedge clk);
        rd_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err  = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        check_val("rst_ready", 32'(rx_ready), 32'(0));
        check_val("rst_data", 32'(rx_data), 32'(0));
        check_val("rst_count", 32'(rx_count), 32'(0));
        check_val("rst_overrun", 32'(rx_overrun), 32'(0));
        check_val("rst_frame_err", 32'(frame_err), 32'(0));
        resetn = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_count"}, 32'(rx_count), 32'(exp_q.size()));
        check_val({tag, "_overrun"}, 32'(rx_overrun), 32'(exp_ovr));
        check_val({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
    endtask

    initial begin
        rxd = 1'b1; rd_strobe = 1'b0; clr_err = 1'b0; resetn = 1'b0;
        exp_ovr = 1'b0; exp_ferr = 1'b0;
        apply_reset();
        tick_wait(4);

        // Single byte, held read strobe pops exactly once
        send_frame(8'hA5, 0, 1'b0);
        check_val("t1_ready", 32'(rx_ready), 32'(1));
        check_val("t1_data", 32'(rx_data), 32'(8'hA5));
        check_status("t1");
        pop_byte(3);
        check_val("t1_ready_after", 32'(rx_ready), 32'(0));
        check_val("t1_data_after", 32'(rx_data), 32'(0));
        check_status("t1_after");

        // Short low glitch is rejected, receiver still works afterwards
        rxd = 1'b0;
        tick_wait(5);
        rxd = 1'b1;
        tick_wait(24);
        check_status("t2");
        send_frame(8'h5A, 0, 1'b0);
        check_status("t2_next");
        pop_byte(1);

        // Overrun on the fifth byte
        foreach (exp_q[i]) ;
        send_frame(8'h01, 0, 1'b0);
        send_frame(8'h02, 0, 1'b0);
        send_frame(8'h03, 0, 1'b0);
        send_frame(8'h04, 0, 1'b0);
        send_frame(8'h55, 0, 1'b0);
        check_status("t3");
        for (int i = 0; i < 5; i++) pop_byte(2);
        check_status("t3_drained");
        pulse_clr();
        check_status("t3_clr");

        // Framing error with long low stop, then a good byte
        send_frame(8'h3C, 40, 1'b0);
        send_frame(8'h7E, 0, 1'b0);
        check_status("t4");
        pop_byte(1);
        pulse_clr();
        check_status("t4_clr");

        // Push into a full FIFO on the same clk as a pop
        send_frame(8'h11, 0, 1'b0);
        send_frame(8'h22, 0, 1'b0);
        send_frame(8'h33, 0, 1'b0);
        send_frame(8'h44, 0, 1'b0);
        check_status("t5_full");
        send_frame(8'h99, 0, 1'b1);
        check_status("t5_collide");
        for (int i = 0; i < 4; i++) pop_byte(1);
        check_status("t5_drained");

        // Reset in the middle of a frame discards it
        rxd = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 4; i++) begin
            rxd = (i < 4) ? 1'b0 : 1'b1;
            tick_wait(16);
        end
        rxd = 1'b1;
        tick_wait(5);
        apply_reset();
        tick_wait(20);
        check_status("t6_reset");
        send_frame(8'h12, 0, 1'b0);
        check_status("t6");
        pop_byte(1);
        check_status("t6_drained");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
